node_port: RTL and testbench
============================

# node_port

Processor-node-side adapter for the router core's node interface. It sits between a processor node and the router core, and is the node end of the core's `Packet_From_Node` / `Core_Load_Ack` / `Packet_To_Node` handshake. Outbound 29-bit requests are held and offered to the core until acknowledged. Inbound 24-bit packets from the core are buffered in a small FIFO that the node drains at its own pace.

## Interface
- `DEPTH`, 4: inbound FIFO entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 255: offer timeout in cycles; used only when `NODE_PORT_TIMEOUT_EN` is defined; range 1..255.

Ports:
- `Clk_R`  in  1  router core clock; the block's only clock.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Node_Req_Valid`  in  1  node has an outbound packet.
- `Node_Req_Data`  in  29  outbound packet.
- `Node_Req_Ready`  out  1  block can accept an outbound packet.
- `Packet_From_Node_Valid`  out  1  outbound packet offered to the core.
- `Packet_From_Node`  out  29  registered outbound packet.
- `Core_Load_Ack`  in  1  core has taken the offered packet.
- `Packet_To_Node_Valid`  in  1  one-cycle strobe carrying one inbound packet.
- `Packet_To_Node`  in  24  inbound packet.
- `Node_Rsp_Valid`  out  1  FIFO not empty.
- `Node_Rsp_Data`  out  24  FIFO head entry.
- `Node_Rsp_Ready`  in  1  node pops the head entry.
- `Drop_Count`  out  8  saturating count of inbound packets dropped on a full FIFO.
- `Tx_Timeout`  out  1  one-cycle pulse when an offer is withdrawn.

## Operation
**Outbound FSM** has two states, IDLE and OFFER.
- IDLE: `Node_Req_Ready` = 1.
  - If `Node_Req_Valid` is high, latch `Node_Req_Data` into `Packet_From_Node` and go to OFFER.
  - `Core_Load_Ack` is ignored in IDLE.
- OFFER: `Packet_From_Node_Valid` = 1 and `Node_Req_Ready` = 0.
  - `Packet_From_Node` holds its value for the whole offer.
  - `Core_Load_Ack` sampled high: go to IDLE.

**Inbound FIFO** is a circular buffer with `$clog2(DEPTH)`-bit read and write pointers plus an occupancy count of width `$clog2(DEPTH)+1`.
- Write occurs when `Packet_To_Node_Valid` is high and the FIFO is not full, or when it is full and a pop happens in the same cycle.
- Pop occurs when `Node_Rsp_Valid` and `Node_Rsp_Ready` are both high.
- `Node_Rsp_Data` = `mem[rd_ptr]`, read directly from registers. There is no fall-through: an empty-FIFO write is visible on the next cycle.
- Write while full with no pop: the packet is discarded and `Drop_Count` increments, saturating at 255.
- Write and pop together while full: both happen and the count is unchanged.
- Write and pop together while empty cannot occur, because `Node_Rsp_Valid` is 0.
- Pointers wrap modulo `DEPTH`.

**Reset** (`Rst_n` low, asynchronous, takes effect at any time including mid-offer or with the FIFO holding data):
- FSM goes to IDLE; pointers and count go to 0; contents are discarded.
- Output values during reset:
  - `Node_Req_Ready` = 1
  - `Packet_From_Node_Valid` = 0
  - `Packet_From_Node` = 0
  - `Node_Rsp_Valid` = 0
  - `Node_Rsp_Data` = don't-care
  - `Drop_Count` = 0
  - `Tx_Timeout` = 0
- FIFO memory itself is not reset.

## Timing
- Outbound: request accepted at edge N; `Packet_From_Node_Valid` is high from N+1.
- `Core_Load_Ack` sampled at edge M: `Packet_From_Node_Valid` is low and `Node_Req_Ready` is high from M+1.
  - The earliest next acceptance is edge M+1, with the next offer at M+2.
  - Peak outbound throughput is one packet per two cycles.
- Inbound: strobe at edge N; `Node_Rsp_Valid` is high from N+1 and `Node_Rsp_Data` shows the packet then.
- Sustained throughput is one packet per cycle when write and pop are both active.
- All outputs are registered except `Node_Req_Ready`, `Node_Rsp_Valid` and `Node_Rsp_Data`. These three decode registered state only and have no combinational path from any input.

## Configuration
- `NODE_PORT_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to OFFER and increments on each OFFER cycle without an ack.
  - When the counter equals `TIMEOUT_CYCLES` and no ack is present, the FSM goes to IDLE and `Tx_Timeout` pulses for one cycle. The packet is discarded.
  - An ack arriving in that same cycle wins: normal completion, no pulse.
- `NODE_PORT_TIMEOUT_EN` undefined: OFFER waits indefinitely, `Tx_Timeout` is tied 0 and the counter is not built.

## Test plan
- Reset, then `Node_Req_Valid`=1 with data `29'h1ABCDEF0` at edge 5 → `Packet_From_Node_Valid`=1 and `Packet_From_Node`=`29'h1ABCDEF0` from edge 6; `Core_Load_Ack` at edge 9 → valid low and ready high at edge 10.
- Five strobes of `24'h000001` through `24'h000005` with `DEPTH`=4 and `Node_Rsp_Ready`=0 → first four are held, `Drop_Count`=1; popping returns 1, 2, 3, 4 in order, then `Node_Rsp_Valid`=0.
- FIFO full, strobe of `24'hAAAAAA` with a simultaneous pop → no drop; after three more pops the head is `24'hAAAAAA`.
- 300 strobes with no pops (`DEPTH`=4) → `Drop_Count` saturates at 255.
- `NODE_PORT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10, no ack → `Tx_Timeout` pulses once, 11 cycles after the offer starts; ack at that same cycle → no pulse.
- Rst_n low mid-offer with 2 entries in the FIFO → both valids drop immediately; after release, `Node_Req_Ready`=1 and `Node_Rsp_Valid`=0.

Source files
------------

// File: rtl/node_port.sv
// node_port: node-side adapter for the router core's node interface.
// Outbound requests are held and offered to the core until acknowledged;
// inbound packets are buffered in a small FIFO that the node drains.
// Optional offer timeout is compiled in with `define NODE_PORT_TIMEOUT_EN.
module node_port #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk_R,
    input  logic        Rst_n,
    input  logic        Node_Req_Valid,
    input  logic [28:0] Node_Req_Data,
    output logic        Node_Req_Ready,
    output logic        Packet_From_Node_Valid,
    output logic [28:0] Packet_From_Node,
    input  logic        Core_Load_Ack,
    input  logic        Packet_To_Node_Valid,
    input  logic [23:0] Packet_To_Node,
    output logic        Node_Rsp_Valid,
    output logic [23:0] Node_Rsp_Data,
    input  logic        Node_Rsp_Ready,
    output logic [7:0]  Drop_Count,
    output logic        Tx_Timeout
);

    localparam int unsigned REQ_W  = 29;
    localparam int unsigned RSP_W  = 24;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    // Elaboration-time parameter sanity checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("node_port: DEPTH must be a power of two and at least 2");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("node_port: TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } out_state_t;

    out_state_t state_q;
    out_state_t state_d;
    logic       load_en;
    logic       timeout_fire;

    // ------------------------------------------------------------------
    // Outbound FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack in the timeout cycle completes normally
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Node_Req_Valid) state_d = OFFER;
            OFFER:   if (Core_Load_Ack || timeout_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        Node_Req_Ready = 1'b0;
        load_en        = 1'b0;
        case (state_q)
            IDLE: begin
                Node_Req_Ready = 1'b1;
                load_en        = Node_Req_Valid;
            end
            default: ;
        endcase
    end

    // Registered offer: valid tracks next state, data captured on acceptance
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            Packet_From_Node_Valid <= 1'b0;
            Packet_From_Node       <= '0;
        end else begin
            Packet_From_Node_Valid <= (state_d == OFFER);
            if (load_en) begin
                Packet_From_Node <= REQ_W'(Node_Req_Data);
            end
        end
    end

`ifdef NODE_PORT_TIMEOUT_EN
    logic [7:0] wait_q;

    assign timeout_fire = (state_q == OFFER) && !Core_Load_Ack
                          && (wait_q == 8'(TIMEOUT_CYCLES));

    // Offer age counter and registered timeout pulse
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_q     <= '0;
            Tx_Timeout <= 1'b0;
        end else begin
            Tx_Timeout <= timeout_fire;
            if (load_en) begin
                wait_q <= '0;
            end else if ((state_q == OFFER) && !Core_Load_Ack) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign Tx_Timeout   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Inbound FIFO
    // ------------------------------------------------------------------

    logic [RSP_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // Head and valid come straight from registers
    assign Node_Rsp_Valid = (count_q != '0);
    assign Node_Rsp_Data  = mem[rd_ptr_q];

    // Push/pop/drop decisions; a full FIFO still accepts when popping
    always_comb begin
        fifo_full = (count_q == CNT_W'(DEPTH));
        pop       = Node_Rsp_Valid && Node_Rsp_Ready;
        wr_en     = Packet_To_Node_Valid && (!fifo_full || pop);
        drop      = Packet_To_Node_Valid && fifo_full && !pop;
    end

    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            Drop_Count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
            if (drop && (Drop_Count != {DROP_W{1'b1}})) begin
                Drop_Count <= Drop_Count + DROP_W'(1);
            end
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge Clk_R) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= Packet_To_Node;
        end
    end

endmodule

// File: tb/tb_node_port.sv
// Testbench for node_port: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_node_port;

    localparam int unsigned DEPTH = 4;
`ifdef NODE_PORT_TIMEOUT_EN
    localparam int unsigned TO = 10;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [28:0] req_data;
    logic        req_ready;
    logic        pfn_valid;
    logic [28:0] pfn;
    logic        ack;
    logic        to_valid;
    logic [23:0] to_data;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        rsp_ready;
    logic [7:0]  drop_count;
    logic        tx_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    node_port #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .Clk_R                 (clk),
        .Rst_n                 (rst_n),
        .Node_Req_Valid        (req_valid),
        .Node_Req_Data         (req_data),
        .Node_Req_Ready        (req_ready),
        .Packet_From_Node_Valid(pfn_valid),
        .Packet_From_Node      (pfn),
        .Core_Load_Ack         (ack),
        .Packet_To_Node_Valid  (to_valid),
        .Packet_To_Node        (to_data),
        .Node_Rsp_Valid        (rsp_valid),
        .Node_Rsp_Data         (rsp_data),
        .Node_Rsp_Ready        (rsp_ready),
        .Drop_Count            (drop_count),
        .Tx_Timeout            (tx_timeout)
    );

    wire [40:0] act_vec = {req_ready, pfn_valid, pfn, rsp_valid, drop_count, tx_timeout};

    // Reference model: a held packet, a queue of inbound packets, a drop tally
    bit          m_busy;
    logic [28:0] m_pkt;
    logic [23:0] m_q[$];
    int          m_drop;
    bit          m_tx;
    int          m_wait;

    task automatic model_reset();
        m_busy = 0; m_pkt = '0; m_q.delete(); m_drop = 0; m_tx = 0; m_wait = 0;
    endtask

    task automatic model_step();
        bit popped;
        m_tx = 0;
        if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1; m_pkt = req_data; m_wait = 0;
            end
        end else if (ack) begin
            m_busy = 0;
        end
`ifdef NODE_PORT_TIMEOUT_EN
        else if (m_wait == int'(TO)) begin
            m_busy = 0; m_tx = 1;
        end else begin
            m_wait++;
        end
`endif
        popped = (m_q.size() > 0) && rsp_ready;
        if (popped) void'(m_q.pop_front());
        if (to_valid) begin
            if (m_q.size() < int'(DEPTH)) m_q.push_back(to_data);
            else if (m_drop < 255) m_drop++;
        end
    endtask

    function automatic logic [40:0] exp_vec();
        return {1'(!m_busy), 1'(m_busy), m_pkt, 1'(m_q.size() > 0), 8'(m_drop), 1'(m_tx)};
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_data = '0; ack = 0; to_valid = 0; to_data = '0; rsp_ready = 0;
    endtask

    // One clock: model follows the same edge, then settle for sampling
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        if ({req_ready, pfn_valid, pfn, rsp_valid, drop_count, tx_timeout} !== {1'b1, 1'b0, 29'h0, 1'b0, 8'h0, 1'b0}) begin
            errors++; $display("FAIL reset_during act=%h exp=%h", act_vec, {1'b1, 41'h0} >> 1);
        end
        checks++;
        apply_reset();
        model_reset();
        cycle();
        if (act_vec !== exp_vec() || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_after act=%h exp=%h", act_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_outbound();
        apply_reset();
        req_valid = 1; req_data = 29'h1ABCDEF0;
        cycle();
        req_valid = 0; req_data = 29'($urandom());
        if ({req_ready, pfn_valid, pfn} !== {1'b0, 1'b1, 29'h1ABCDEF0}) begin
            errors++; $display("FAIL offer_start act=%b/%b/%h exp=0/1/1abcdef0", req_ready, pfn_valid, pfn);
        end
        checks++;
        req_valid = 1;
        repeat (3) cycle();
        if ({req_ready, pfn_valid, pfn} !== {1'b0, 1'b1, 29'h1ABCDEF0}) begin
            errors++; $display("FAIL offer_hold act=%b/%b/%h exp=0/1/1abcdef0", req_ready, pfn_valid, pfn);
        end
        checks++;
        req_valid = 0; ack = 1;
        cycle();
        ack = 0;
        if ({req_ready, pfn_valid} !== 2'b10) begin
            errors++; $display("FAIL ack_release act=%b%b exp=10", req_ready, pfn_valid);
        end
        checks++;
        ack = 1;
        repeat (2) cycle();
        ack = 0;
        if ({req_ready, pfn_valid, pfn} !== {1'b1, 1'b0, 29'h1ABCDEF0}) begin
            errors++; $display("FAIL ack_in_idle act=%b/%b/%h exp=1/0/1abcdef0", req_ready, pfn_valid, pfn);
        end
        checks++;
`ifndef NODE_PORT_TIMEOUT_EN
        req_valid = 1; req_data = 29'h0123457;
        cycle();
        req_valid = 0;
        repeat (300) cycle();
        if ({pfn_valid, pfn, tx_timeout} !== {1'b1, 29'h0123457, 1'b0}) begin
            errors++; $display("FAIL offer_indefinite act=%b/%h/%b exp=1/0123457/0", pfn_valid, pfn, tx_timeout);
        end
        checks++;
`endif
    endtask

    task automatic test_fifo_drop();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            to_valid = 1; to_data = 24'(i);
            cycle();
        end
        to_valid = 0;
        if ({drop_count, rsp_valid, rsp_data} !== {8'd1, 1'b1, 24'h000001}) begin
            errors++; $display("FAIL fill_drop act=%0d/%b/%h exp=1/1/000001", drop_count, rsp_valid, rsp_data);
        end
        checks++;
        for (int i = 1; i <= 4; i++) begin
            if ({rsp_valid, rsp_data} !== {1'b1, 24'(i)}) begin
                errors++; $display("FAIL pop_order_%0d act=%b/%h exp=1/%h", i, rsp_valid, rsp_data, 24'(i));
            end
            checks++;
            rsp_ready = 1;
            cycle();
            rsp_ready = 0;
        end
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL drained act=%b exp=0", rsp_valid);
        end
        checks++;
    endtask

    task automatic test_full_pop_write();
        logic [23:0] vals [4];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            vals[i] = 24'($urandom());
            to_valid = 1; to_data = vals[i];
            cycle();
        end
        to_valid = 1; to_data = 24'hAAAAAA; rsp_ready = 1;
        cycle();
        to_valid = 0;
        if ({drop_count, rsp_valid, rsp_data} !== {8'd0, 1'b1, vals[1]}) begin
            errors++; $display("FAIL full_pop_write act=%0d/%b/%h exp=0/1/%h", drop_count, rsp_valid, rsp_data, vals[1]);
        end
        checks++;
        repeat (3) cycle();
        rsp_ready = 0;
        if ({rsp_valid, rsp_data} !== {1'b1, 24'hAAAAAA}) begin
            errors++; $display("FAIL head_after_pops act=%b/%h exp=1/aaaaaa", rsp_valid, rsp_data);
        end
        checks++;
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 1; i <= 300; i++) begin
            to_valid = 1; to_data = 24'($urandom());
            cycle();
            if (i == 258) begin
                if (drop_count !== 8'd254) begin
                    errors++; $display("FAIL drop_pre_sat act=%0d exp=254", drop_count);
                end
                checks++;
            end
        end
        to_valid = 0;
        if (drop_count !== 8'd255) begin
            errors++; $display("FAIL drop_saturate act=%0d exp=255", drop_count);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int offers = 0;
        apply_reset();
        req_valid = 1; ack = 1; rsp_ready = 1;
        for (int i = 0; i < 20; i++) begin
            req_data = 29'($urandom());
            to_valid = 1; to_data = 24'($urandom());
            cycle();
            if (pfn_valid === 1'b1) offers++;
            if (act_vec !== exp_vec() || (m_q.size() > 0 && rsp_data !== m_q[0])) begin
                errors++; $display("FAIL b2b_cycle_%0d act=%h/%h exp=%h", i, act_vec, rsp_data, exp_vec());
            end
            checks++;
        end
        idle_inputs();
        if (offers != 10) begin
            errors++; $display("FAIL b2b_offer_rate act=%0d exp=10", offers);
        end
        checks++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            req_valid = 1'($urandom_range(0, 2) != 0);
            req_data  = 29'($urandom());
            ack       = 1'($urandom_range(0, 3) == 0);
            to_valid  = 1'($urandom_range(0, 1));
            to_data   = 24'($urandom());
            rsp_ready = 1'($urandom_range(0, 2) == 0);
            cycle();
            if (act_vec !== exp_vec() || (m_q.size() > 0 && rsp_data !== m_q[0])) begin
                errors++; $display("FAIL random_cycle_%0d act=%h/%h exp=%h", i, act_vec, rsp_data, exp_vec());
            end
            checks++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = 1; req_data = 29'($urandom()); to_valid = 1; to_data = 24'h00C0DE;
        cycle();
        req_valid = 0; to_data = 24'h00BEEF;
        cycle();
        to_valid = 0;
        if ({pfn_valid, rsp_valid, rsp_data} !== {1'b1, 1'b1, 24'h00C0DE}) begin
            errors++; $display("FAIL pre_reset act=%b/%b/%h exp=1/1/00c0de", pfn_valid, rsp_valid, rsp_data);
        end
        checks++;
        #2 rst_n = 0;
        #1;
        if ({req_ready, pfn_valid, pfn, rsp_valid, drop_count, tx_timeout} !== {1'b1, 1'b0, 29'h0, 1'b0, 8'h0, 1'b0}) begin
            errors++; $display("FAIL reset_async act=%h exp=%h", act_vec, {2'b10, 39'h0});
        end
        checks++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cycle();
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_release act=%b%b exp=10", req_ready, rsp_valid);
        end
        checks++;
    endtask

`ifdef NODE_PORT_TIMEOUT_EN
    task automatic test_timeout();
        int pulses = 0;
        apply_reset();
        req_valid = 1; req_data = 29'h0F0F0F0;
        cycle();
        req_valid = 0;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            if (tx_timeout === 1'b1) pulses++;
            if ({tx_timeout, pfn_valid} !== {1'(k == 11), 1'(k < 11)}) begin
                errors++; $display("FAIL timeout_k%0d act=%b%b exp=%b%b", k, tx_timeout, pfn_valid, 1'(k == 11), 1'(k < 11));
            end
            checks++;
        end
        if (pulses != 1) begin
            errors++; $display("FAIL timeout_pulses act=%0d exp=1", pulses);
        end
        checks++;
        apply_reset();
        req_valid = 1;
        cycle();
        req_valid = 0;
        repeat (10) cycle();
        ack = 1;
        cycle();
        ack = 0;
        if ({tx_timeout, pfn_valid} !== 2'b00) begin
            errors++; $display("FAIL timeout_ack_wins act=%b%b exp=00", tx_timeout, pfn_valid);
        end
        checks++;
        repeat (3) cycle();
        if (tx_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_no_late_pulse act=%b exp=0", tx_timeout);
        end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_outbound();
        test_fifo_drop();
        test_full_pop_write();
        test_saturate();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef NODE_PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
